// File: rtl/milano_pkg.sv
// Shared types for the milano core's load/store path.
// Holds the LSU operation and state encodings plus access-size helpers.
package milano_pkg;

    typedef enum logic [3:0] {
        LSU_NONE,
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsu_opt_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } lsu_size_e;

    function automatic lsu_size_e lsu_size(input lsu_opt_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: lsu_size = SIZE_B;
            LSU_LH, LSU_LHU, LSU_SH: lsu_size = SIZE_H;
            default:                 lsu_size = SIZE_W;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_opt_e op, input logic [1:0] off);
        case (lsu_size(op))
            SIZE_H:  lsu_misaligned = off[0];
            SIZE_W:  lsu_misaligned = |off;
            default: lsu_misaligned = 1'b0;
        endcase
    endfunction

    // Clears the low address bits so halves and words sit on their natural boundary.
    function automatic logic [31:0] lsu_natural_align(input lsu_opt_e op, input logic [31:0] addr);
        case (lsu_size(op))
            SIZE_H:  lsu_natural_align = {addr[31:1], 1'b0};
            SIZE_W:  lsu_natural_align = {addr[31:2], 2'b00};
            default: lsu_natural_align = addr;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and replicated store data on the way out,
// lane extraction with sign/zero extension on the way back.
module lsu_align
    import milano_pkg::*;
(
    input  lsu_opt_e    op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = 32'h0;

        case (offset)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

        case (lsu_size(op))
            SIZE_B: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase

        case (op)
            LSU_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            LSU_LBU: load_data = {24'h0, lane_byte};
            LSU_LH:  load_data = {{16{lane_half[15]}}, lane_half};
            LSU_LHU: load_data = {16'h0, lane_half};
            LSU_LW:  load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: req/gnt/rvalid data-memory handshake with a single-cycle write-back.
// Define MILANO_LSU_MISALIGN_CHK_EN to reject misaligned H/W accesses with lsu_err_o.
module lsu
    import milano_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  lsu_opt_e    lsu_operate_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_rdata_o,
    output logic        lsu_err_o
);

    lsu_state_e  state_q;
    lsu_opt_e    op_q;
    logic        we_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] cnt_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_rdata_q;
    logic        err_q;

    logic [31:0] addr_sum;
    logic        accept;
    logic        reject;
    logic        issue;
    logic        timeout;
    logic        in_req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    assign addr_sum = operand_a_i + operand_b_i;

    // The write-back cycle still counts as busy so the next accept lands one cycle later.
    assign accept = (state_q == IDLE) && !wb_valid_q && lsu_req_i && (lsu_operate_i != LSU_NONE);

`ifdef MILANO_LSU_MISALIGN_CHK_EN
    assign reject = accept && lsu_misaligned(lsu_operate_i, addr_sum[1:0]);
`else
    assign reject = 1'b0;
`endif

    assign issue   = accept && !reject;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= (32'(TIMEOUT_CYCLES) - 32'd1));
    assign in_req  = (state_q == REQ);

    lsu_align u_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (data_rdata_i),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    // Handshake sequencing; completion takes priority over a coincident timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= LSU_NONE;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            addr_q     <= 32'h0;
            sdata_q    <= 32'h0;
            cnt_q      <= 32'h0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_rdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 32'h0;
                    if (reject) begin
                        err_q <= 1'b1;
                    end else if (issue) begin
                        addr_q  <= lsu_natural_align(lsu_operate_i, addr_sum);
                        op_q    <= lsu_operate_i;
                        we_q    <= lsu_we_i;
                        rd_q    <= rd_addr_i;
                        sdata_q <= store_data_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (data_gnt_i) begin
                        state_q <= RESP;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (data_rvalid_i) begin
                        if (!we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_rdata_q <= load_data;
                        end
                        state_q <= IDLE;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_busy_o   = (state_q != IDLE) || wb_valid_q;
    assign data_req_o   = in_req;
    assign data_we_o    = in_req && we_q;
    assign data_be_o    = in_req ? be : 4'b0000;
    assign data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign data_wdata_o = in_req ? wdata : 32'h0;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_rdata_o   = wb_rdata_q;
    assign lsu_err_o    = err_q;

endmodule
